// File: rtl/wm_pkg.sv
// ---------------------------------------------------------------------------
// wm_pkg
// Shared definitions for the washing-machine plant responder: phase ids,
// FSM state encoding, phase durations in ticks, input field encodings and
// helpers that map a command vector to a phase and a phase to its length.
// ---------------------------------------------------------------------------
package wm_pkg;

  typedef enum logic [2:0] {
    PH_FILL  = 3'd0,
    PH_WASH  = 3'd1,
    PH_RINSE = 3'd2,
    PH_SPIN  = 3'd3,
    PH_DRAIN = 3'd4,
    PH_DRY   = 3'd5
  } phase_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  localparam int unsigned FILL_T        = 8;
  localparam int unsigned RINSE_T       = 10;
  localparam int unsigned SPIN_T_COTTON = 6;
  localparam int unsigned SPIN_T_OTHER  = 4;
  localparam int unsigned DRAIN_T       = 5;
  localparam int unsigned DRY_T_COTTON  = 20;
  localparam int unsigned DRY_T_OTHER   = 12;
  localparam int unsigned WASH_T_30     = 30;
  localparam int unsigned WASH_T_45     = 45;
  localparam int unsigned WASH_T_60     = 60;

  localparam logic [1:0] TEMP_COLD     = 2'b00;
  localparam logic [1:0] TEMP_WARM     = 2'b01;
  localparam logic [1:0] TEMP_HOT      = 2'b10;
  localparam logic [1:0] TEMP_COLD_ALT = 2'b11;

  localparam logic [1:0] CLOTH_COTTON  = 2'b00;

  localparam logic [1:0] CYC_30        = 2'b00;
  localparam logic [1:0] CYC_45        = 2'b01;
  localparam logic [1:0] CYC_60        = 2'b10;
  localparam logic [1:0] CYC_30_ALT    = 2'b11;

  // Only a single-hot vector is ever loaded; anything else maps to fill.
  function automatic phase_e onehot_to_phase(input logic [5:0] cmds);
    case (cmds)
      6'b000010: return PH_WASH;
      6'b000100: return PH_RINSE;
      6'b001000: return PH_SPIN;
      6'b010000: return PH_DRAIN;
      6'b100000: return PH_DRY;
      default:   return PH_FILL;
    endcase
  endfunction

  function automatic int unsigned phase_ticks(input phase_e ph, input logic [1:0] cyc,
                                              input logic [1:0] cloth);
    case (ph)
      PH_WASH: begin
        case (cyc)
          CYC_45:  return WASH_T_45;
          CYC_60:  return WASH_T_60;
          default: return WASH_T_30;
        endcase
      end
      PH_RINSE: return RINSE_T;
      PH_SPIN:  return (cloth == CLOTH_COTTON) ? SPIN_T_COTTON : SPIN_T_OTHER;
      PH_DRAIN: return DRAIN_T;
      PH_DRY:   return (cloth == CLOTH_COTTON) ? DRY_T_COTTON : DRY_T_OTHER;
      default:  return FILL_T;
    endcase
  endfunction

  function automatic logic temp_heated(input logic [1:0] t);
    return (t == TEMP_WARM) || (t == TEMP_HOT);
  endfunction

endpackage

// File: rtl/wm_tick_prescaler.sv
// ---------------------------------------------------------------------------
// wm_tick_prescaler
// Divides clk down to one tick every DIV enabled cycles.
//   clk, reset : clock, asynchronous active-high reset
//   i_clr      : synchronous clear of the divider (wins over i_en)
//   i_en       : advance the divider this cycle
//   o_tick     : high in the enabled cycle that completes a DIV-cycle period
// ---------------------------------------------------------------------------
module wm_tick_prescaler #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int W = $clog2(DIV);

  logic [W-1:0] r_cnt;

  // The tick is combinational so the consumer acts on the same edge that
  // wraps the divider; the phase latency then lands exactly on D*DIV+1.
  assign o_tick = i_en && !i_clr && (r_cnt == W'(DIV - 1));

  // Divider counter: frozen when disabled, wraps to zero on each tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt == W'(DIV - 1)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/washer_plant_responder.sv
// ---------------------------------------------------------------------------
// washer_plant_responder
// Plant side of the washer controller handshake: times each commanded phase
// and answers with done levels, a door latch and heater / error status.
//   clk, reset           : clock, asynchronous active-high reset
//   i_lock_door          : door lock request (level)
//   i_fill_water..i_dry  : one-hot phase commands (levels)
//   i_pause              : freezes the phase timebase
//   i_cycle_duration     : wash length select, sampled at phase load
//   i_cloth_type         : cotton / delicate, sampled at phase load
//   i_temp_select        : wash water temperature
//   o_door_locked        : door latch status
//   o_*_done             : phase-complete levels, held while the command is
//   o_heater_on          : heater drive during a heated wash
//   o_cmd_error          : more than one phase command seen
// ---------------------------------------------------------------------------
module washer_plant_responder
  import wm_pkg::*;
#(
  parameter int TICK_DIV   = 1000,
  parameter int LOCK_TICKS = 2,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_lock_door,
  input  logic       i_fill_water,
  input  logic       i_wash,
  input  logic       i_rinse,
  input  logic       i_spin,
  input  logic       i_drain,
  input  logic       i_dry,
  input  logic       i_pause,
  input  logic [1:0] i_cycle_duration,
  input  logic [1:0] i_cloth_type,
  input  logic [1:0] i_temp_select,
  output logic       o_door_locked,
  output logic       o_fill_done,
  output logic       o_wash_done,
  output logic       o_rinse_done,
  output logic       o_spin_done,
  output logic       o_drain_done,
  output logic       o_dry_done,
  output logic       o_heater_on,
  output logic       o_cmd_error
);

  localparam int LOCK_W = $clog2(LOCK_TICKS + 1);

  state_e             r_state, w_nxt_state;
  phase_e             r_phase, w_nxt_phase, w_load_phase;
  logic [CNT_W-1:0]   r_count, w_nxt_count, w_load_count;
  logic [5:0]         w_cmds, w_latched;
  logic               w_single, w_multi, w_load, w_resume, w_door_clr;
  logic               w_ph_clr, w_ph_en, w_ph_tick;
  logic               r_lock_q, w_lock_tick;
  logic [LOCK_W-1:0]  r_lock_ticks;

  assign w_cmds    = {i_dry, i_drain, i_spin, i_rinse, i_wash, i_fill_water};
  assign w_latched = 6'b000001 << r_phase;
  assign w_multi   = (w_cmds & (w_cmds - 6'd1)) != 6'd0;
  assign w_single  = (w_cmds != 6'd0) && !w_multi;

  assign w_load_phase = onehot_to_phase(w_cmds);
  assign w_load_count = CNT_W'(phase_ticks(w_load_phase, i_cycle_duration, i_cloth_type) - 32'd1);

  // A held phase resumes only when its own command comes back alone; a
  // different lone command starts a fresh phase from a cleared timebase.
  assign w_resume = (r_state == ST_HOLD) && (w_cmds == w_latched);
  assign w_load   = w_single && ((r_state == ST_IDLE) ||
                                 ((r_state == ST_HOLD) && (w_cmds != w_latched)));

  // The resume cycle itself advances the timebase, so a hold costs exactly
  // the cycles spent paused and nothing more.
  assign w_ph_clr = w_load || (r_state == ST_IDLE) || (r_state == ST_DONE) ||
                    (r_state == ST_ERROR);
  assign w_ph_en  = !i_pause && ((r_state == ST_RUN) || w_resume);

  wm_tick_prescaler #(.DIV(TICK_DIV)) u_phase_tick (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_ph_clr),
    .i_en   (w_ph_en),
    .o_tick (w_ph_tick)
  );

  // The lock path counts from a registered copy of the request, which gives
  // door_locked the same one-cycle sampling latency as the phase outputs.
  wm_tick_prescaler #(.DIV(TICK_DIV)) u_lock_tick (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (!r_lock_q),
    .i_en   (r_lock_q),
    .o_tick (w_lock_tick)
  );

  // Next-state logic. In RUN a dropped command is checked before the tick,
  // so a drop that coincides with the final tick never reports done.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_phase = r_phase;
    w_nxt_count = r_count;
    w_door_clr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_multi) w_nxt_state = ST_ERROR;
      end
      ST_RUN: begin
        if ((w_cmds & ~w_latched) != 6'd0) begin
          w_nxt_state = ST_ERROR;
        end else if ((w_cmds & w_latched) == 6'd0) begin
          w_nxt_state = i_pause ? ST_HOLD : ST_IDLE;
        end else if (w_ph_tick) begin
          if (r_count == '0) w_nxt_state = ST_DONE;
          else               w_nxt_count = r_count - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (w_multi) begin
          w_nxt_state = ST_ERROR;
        end else if (w_resume) begin
          w_nxt_state = ST_RUN;
          if (w_ph_tick) begin
            if (r_count == '0) w_nxt_state = ST_DONE;
            else               w_nxt_count = r_count - CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        if ((w_cmds & w_latched) == 6'd0) begin
          w_nxt_state = ST_IDLE;
          w_door_clr  = (r_phase == PH_DRY);
        end
      end
      ST_ERROR: begin
        if (w_cmds == 6'd0) w_nxt_state = ST_IDLE;
      end
      default: w_nxt_state = ST_IDLE;
    endcase
    if (w_load) begin
      w_nxt_state = ST_RUN;
      w_nxt_phase = w_load_phase;
      w_nxt_count = w_load_count;
    end
  end

  // Phase FSM state plus its registered status outputs, all derived from
  // the next state so they change on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_phase      <= PH_FILL;
      r_count      <= '0;
      o_fill_done  <= 1'b0;
      o_wash_done  <= 1'b0;
      o_rinse_done <= 1'b0;
      o_spin_done  <= 1'b0;
      o_drain_done <= 1'b0;
      o_dry_done   <= 1'b0;
      o_heater_on  <= 1'b0;
      o_cmd_error  <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_phase      <= w_nxt_phase;
      r_count      <= w_nxt_count;
      o_fill_done  <= (w_nxt_state == ST_DONE) && (w_nxt_phase == PH_FILL);
      o_wash_done  <= (w_nxt_state == ST_DONE) && (w_nxt_phase == PH_WASH);
      o_rinse_done <= (w_nxt_state == ST_DONE) && (w_nxt_phase == PH_RINSE);
      o_spin_done  <= (w_nxt_state == ST_DONE) && (w_nxt_phase == PH_SPIN);
      o_drain_done <= (w_nxt_state == ST_DONE) && (w_nxt_phase == PH_DRAIN);
      o_dry_done   <= (w_nxt_state == ST_DONE) && (w_nxt_phase == PH_DRY);
      o_heater_on  <= (w_nxt_state == ST_RUN) && (w_nxt_phase == PH_WASH) &&
                      temp_heated(i_temp_select);
      o_cmd_error  <= (w_nxt_state == ST_ERROR);
    end
  end

  // Door latch: sets once the request has survived LOCK_TICKS consecutive
  // ticks, and only the end of a dry phase releases it. A release on the
  // same edge as a set takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock_q      <= 1'b0;
      r_lock_ticks  <= '0;
      o_door_locked <= 1'b0;
    end else begin
      r_lock_q <= i_lock_door;
      if (!r_lock_q) begin
        r_lock_ticks <= '0;
      end else if (w_lock_tick && (r_lock_ticks != LOCK_W'(LOCK_TICKS))) begin
        r_lock_ticks <= r_lock_ticks + LOCK_W'(1);
      end
      if (w_door_clr) begin
        o_door_locked <= 1'b0;
      end else if (r_lock_q && w_lock_tick && (r_lock_ticks == LOCK_W'(LOCK_TICKS - 1))) begin
        o_door_locked <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_washer_plant_responder.sv
// ---------------------------------------------------------------------------
// tb_washer_plant_responder
// Directed bench for washer_plant_responder with TICK_DIV=4, LOCK_TICKS=2.
// Inputs are driven and outputs sampled on the falling edge; expected values
// are queued when stimulus is applied and popped when the DUT answers.
// ---------------------------------------------------------------------------
module tb_washer_plant_responder;

  localparam int TD = 4;

  logic       clk;
  logic       reset;
  logic       lockDoor, fill, wash, rinse, spin, drain, dry, pause;
  logic [1:0] cycleDur, clothType, tempSel;
  logic       doorLocked, fillDone, washDone, rinseDone, spinDone, drainDone, dryDone;
  logic       heaterOn, cmdError;
  logic [5:0] doneVec;
  logic [8:0] outVec;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } expect_t;

  expect_t sb[$];
  int      compareCount = 0;
  int      failCount    = 0;
  int      lat;
  int      heat;

  assign doneVec = {dryDone, drainDone, spinDone, rinseDone, washDone, fillDone};
  assign outVec  = {doorLocked, doneVec, heaterOn, cmdError};

  washer_plant_responder #(
    .TICK_DIV   (TD),
    .LOCK_TICKS (2),
    .CNT_W      (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .i_lock_door      (lockDoor),
    .i_fill_water     (fill),
    .i_wash           (wash),
    .i_rinse          (rinse),
    .i_spin           (spin),
    .i_drain          (drain),
    .i_dry            (dry),
    .i_pause          (pause),
    .i_cycle_duration (cycleDur),
    .i_cloth_type     (clothType),
    .i_temp_select    (tempSel),
    .o_door_locked    (doorLocked),
    .o_fill_done      (fillDone),
    .o_wash_done      (washDone),
    .o_rinse_done     (rinseDone),
    .o_spin_done      (spinDone),
    .o_drain_done     (drainDone),
    .o_dry_done       (dryDone),
    .o_heater_on      (heaterOn),
    .o_cmd_error      (cmdError)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a wait is ever left unbounded.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected normal end");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [5:0] cmds, input logic p);
    {dry, drain, spin, rinse, wash, fill} = cmds;
    pause = p;
  endtask

  task automatic pushExpect(input string tag, input logic [31:0] value);
    expect_t e;
    e.tag   = tag;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    expect_t e;
    compareCount++;
    if (sb.size() == 0) begin
      failCount++;
      $error("[TB] FAIL scoreboard_empty: observed %0d expected none", observed);
    end else begin
      e = sb.pop_front();
      assert (observed === e.value) else begin
        failCount++;
        $error("[TB] FAIL %s: observed %0d expected %0d", e.tag, observed, e.value);
      end
    end
  endtask

  // Counts falling edges until the selected done rises or the budget runs out.
  task automatic waitDone(input int idx, input int budget, output int latency);
    latency = 0;
    while ((doneVec[idx] !== 1'b1) && (latency < budget)) begin
      @(negedge clk);
      latency++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    lockDoor  = 1'b0;
    cycleDur  = 2'b00;
    clothType = 2'b00;
    tempSel   = 2'b01;
    applyStimulus(6'b000000, 1'b0);

    repeat (2) @(negedge clk);
    pushExpect("reset_outputs", 0);
    checkOutput(32'(outVec));
    reset = 1'b0;
    @(negedge clk);
    pushExpect("idle_after_reset", 0);
    checkOutput(32'(outVec));

    // Heated 30-tick wash.
    pushExpect("wash_done_cycle", 30 * TD + 1);
    pushExpect("heater_run_cycles", 30 * TD);
    pushExpect("heater_off_at_done", 0);
    applyStimulus(6'b000010, 1'b0);
    lat  = 0;
    heat = 0;
    while ((washDone !== 1'b1) && (lat < 200)) begin
      @(negedge clk);
      lat++;
      if ((heaterOn === 1'b1) && (washDone !== 1'b1)) heat++;
    end
    checkOutput(lat);
    checkOutput(heat);
    checkOutput(32'(heaterOn));
    repeat (3) @(negedge clk);
    pushExpect("wash_done_held", 1);
    checkOutput(32'(washDone));
    applyStimulus(6'b000000, 1'b0);
    @(negedge clk);
    pushExpect("wash_done_fall", 0);
    checkOutput(32'(washDone));
    @(negedge clk);

    // Spin, delicate then cotton.
    clothType = 2'b01;
    pushExpect("spin_delicate_cycle", 4 * TD + 1);
    applyStimulus(6'b001000, 1'b0);
    waitDone(3, 100, lat);
    checkOutput(lat);
    applyStimulus(6'b000000, 1'b0);
    repeat (2) @(negedge clk);
    clothType = 2'b00;
    pushExpect("spin_cotton_cycle", 6 * TD + 1);
    applyStimulus(6'b001000, 1'b0);
    waitDone(3, 100, lat);
    checkOutput(lat);
    applyStimulus(6'b000000, 1'b0);
    repeat (2) @(negedge clk);

    // Rinse with a 20-cycle paused drop starting at cycle 10.
    pushExpect("rinse_hold_no_done", 0);
    pushExpect("rinse_paused_cycle", 10 * TD + 1 + 20);
    applyStimulus(6'b000100, 1'b0);
    repeat (10) @(negedge clk);
    applyStimulus(6'b000000, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput(32'(rinseDone));
    applyStimulus(6'b000100, 1'b0);
    waitDone(2, 100, lat);
    checkOutput(lat + 30);
    applyStimulus(6'b000000, 1'b0);
    repeat (2) @(negedge clk);

    // Two commands from idle.
    pushExpect("err_asserts", 1);
    pushExpect("err_no_done", 0);
    pushExpect("err_held_no_done", 0);
    pushExpect("err_still_set", 1);
    pushExpect("err_clears", 0);
    applyStimulus(6'b000011, 1'b0);
    @(negedge clk);
    checkOutput(32'(cmdError));
    checkOutput(32'(doneVec));
    repeat (39) @(negedge clk);
    checkOutput(32'(doneVec));
    checkOutput(32'(cmdError));
    applyStimulus(6'b000000, 1'b0);
    @(negedge clk);
    checkOutput(32'(cmdError));
    @(negedge clk);

    // Second command rising while drain runs.
    pushExpect("run_second_cmd_err", 1);
    applyStimulus(6'b010000, 1'b0);
    repeat (5) @(negedge clk);
    applyStimulus(6'b110000, 1'b0);
    @(negedge clk);
    checkOutput(32'(cmdError));
    applyStimulus(6'b000000, 1'b0);
    repeat (2) @(negedge clk);

    // Lock request dropped too early must not latch the door.
    pushExpect("lock_restart_no_lock", 0);
    lockDoor = 1'b1;
    repeat (5) @(negedge clk);
    lockDoor = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput(32'(doorLocked));

    // Full lock sequence.
    pushExpect("lock_before_cycle9", 0);
    pushExpect("lock_set_cycle9", 1);
    lockDoor = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput(32'(doorLocked));
    @(negedge clk);
    checkOutput(32'(doorLocked));
    lockDoor = 1'b0;
    @(negedge clk);

    // Cotton dry releases the door when it ends.
    pushExpect("dry_cotton_cycle", 20 * TD + 1);
    pushExpect("lock_during_dry", 1);
    pushExpect("lock_kept_at_drop", 1);
    pushExpect("dry_done_fall", 0);
    pushExpect("lock_released", 0);
    applyStimulus(6'b100000, 1'b0);
    waitDone(5, 200, lat);
    checkOutput(lat);
    checkOutput(32'(doorLocked));
    @(negedge clk);
    checkOutput(32'(doorLocked));
    applyStimulus(6'b000000, 1'b0);
    @(negedge clk);
    checkOutput(32'(dryDone));
    checkOutput(32'(doorLocked));

    // Reset in the middle of a drain with the door locked.
    pushExpect("lock_before_reset", 1);
    lockDoor = 1'b1;
    repeat (9) @(negedge clk);
    lockDoor = 1'b0;
    checkOutput(32'(doorLocked));
    pushExpect("async_reset_outputs", 0);
    applyStimulus(6'b010000, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput(32'(outVec));
    applyStimulus(6'b000000, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    pushExpect("after_reset_release", 0);
    checkOutput(32'(outVec));
    pushExpect("drain_restart_cycle", 5 * TD + 1);
    applyStimulus(6'b010000, 1'b0);
    waitDone(4, 100, lat);
    checkOutput(lat);
    applyStimulus(6'b000000, 1'b0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/washer_plant_responder.md
# washer_plant_responder

Responder side of the washing-machine controller handshake. It accepts the controller's one-hot actuator commands (lock_door, fill_water, wash, rinse, spin, drain, dry) and returns the matching completion and status signals (door_locked, *_done) after programmed phase durations. Durations are set by cycle_duration and cloth_type. Used as the appliance plant in system simulation and as the phase-timing engine on FPGA bring-up.

## Interface
- TICK_DIV, 1000: clk cycles per time tick, ≥2
- LOCK_TICKS, 2: ticks lock_door must stay high before door_locked sets
- CNT_W, 8: phase tick counter width
- clk  in  1  clock
- reset  in  1  asynchronous, active-high; clock clk
- lock_door, fill_water, wash, rinse, spin, drain, dry  in  1 each  controller actuator commands, levels
- pause  in  1  freezes the timebase and latches pause intent
- cycle_duration  in  2  00=30, 01=45, 10=60, 11=30 wash ticks
- cloth_type  in  2  00=cotton, other values=delicate
- temp_select  in  2  00=cold, 01/10=heated, 11=cold
- door_locked  out  1  door latch status, level
- fill_done, wash_done, rinse_done, spin_done, drain_done, dry_done  out  1 each  phase-complete levels
- heater_on  out  1  high in wash RUN when temp is heated
- cmd_error  out  1  more than one phase command is high

## Operation
- Phase commands: fill_water, wash, rinse, spin, drain, dry. "Single" means exactly one of them is high.
- Durations in ticks:
  - fill 8
  - wash from cycle_duration
  - rinse 10
  - spin 6 for cotton, 4 otherwise
  - drain 5
  - dry 20 for cotton, 12 otherwise
- cycle_duration and cloth_type are sampled only at phase load.
- States:
  - IDLE: single cmd → load phase id, count=D-1, prescaler=0, go to RUN. More than one cmd → ERROR.
  - RUN:
    - When pause is low, the prescaler advances.
    - On a tick with count==0 → DONE; otherwise count decrements.
    - Latched cmd drops with pause high → HOLD.
    - Latched cmd drops with pause low → IDLE (abort, no done).
    - Any second cmd rises → ERROR.
  - HOLD: count and prescaler are retained.
    - Same cmd returns alone → RUN.
    - A different single cmd → fresh load, go to RUN.
    - More than one cmd → ERROR.
  - DONE: the matching *_done is high while the cmd is held. Cmd drops → IDLE.
  - ERROR: cmd_error=1 and all *_done=0. All phase cmds low → IDLE.
- door_locked:
  - Sets after lock_door has been high for LOCK_TICKS consecutive ticks. It uses its own lock prescaler, running in parallel with the phase FSM.
  - Clears when leaving a DONE state whose phase is dry.
  - Otherwise stays set, including through pause and abort.
- heater_on = (state==RUN) && phase==wash && temp_select∈{01,10}.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- All outputs are registered.
- A cmd first high at cycle 0, with no pause → *_done high at cycle D·TICK_DIV+1.
- Each paused cycle adds 1 to that latency.
- Done deasserts 1 cycle after the cmd drops.
- Lock sequence: lock_door first high at cycle 0 → door_locked high at cycle LOCK_TICKS·TICK_DIV+1. A drop before then restarts the count.
- cmd_error asserts 1 cycle after a multi-cmd sample and deasserts 1 cycle after all cmds are low.
- Counter: CNT_W bits, no wrap; the maximum duration is 60 ticks.
- Reset mid-phase: immediate return to IDLE, all outputs 0, door_locked 0.
- Simultaneous cmd drop and final tick in RUN: the drop wins.
  - pause low → IDLE.
  - pause high → HOLD with count=0; on resume, done follows the next tick.

## Structure
- Package wm_pkg holds:
  - phase id enum: PH_FILL…PH_DRY
  - duration constants: FILL_T, RINSE_T, SPIN_T_COTTON/OTHER, DRAIN_T, DRY_T_COTTON/OTHER, WASH_T_30/45/60
  - encodings of temp_select, cloth_type and cycle_duration
- One sub-module, wm_tick_prescaler: synchronous clear, enable input, tick output. It is instantiated twice, once for the phase timebase and once for the lock timebase.

## Test plan
- TICK_DIV=4, cycle_duration=00, wash held from cycle 0 → wash_done rises at cycle 121 and falls 1 cycle after wash drops; heater_on=1 throughout RUN when temp_select=01.
- cloth_type=01, spin held → spin_done at cycle 17 (4 ticks); with cloth_type=00 → cycle 25.
- rinse running; at cycle 10, pause high and rinse dropped for 20 cycles; rinse reasserted and pause low → rinse_done at cycle 61.
- fill and wash high together → cmd_error=1 next cycle, no *_done; both dropped → cmd_error=0 one cycle later.
- lock_door high for 9 cycles → door_locked=1; full dry phase completes and dry drops → door_locked=0.
- reset asserted mid-drain with door_locked=1 → all outputs 0 immediately; drain reasserted after release → full 5-tick duration restarts.
